// File: rtl/sha2_pkg.sv
// SHA-2 round-constant tables, variant helpers and the sequencer state type.
// Shared by sha2_k_rom and sha2_k_sequencer.
package sha2_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} kseq_state_e;

  localparam logic [31:0] K256 [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [63:0] K512 [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  function automatic int variant_w(input int v);
    return (v == 512) ? 64 : 32;
  endfunction

  function automatic int variant_rounds(input int v);
    return (v == 512) ? 80 : 64;
  endfunction

endpackage

// File: rtl/sha2_k_rom.sv
// Combinational K[t] lookup for one lane; table chosen by VARIANT at elaboration.
module sha2_k_rom import sha2_pkg::*; #(
  parameter  int VARIANT = 256,
  localparam int W       = variant_w(VARIANT),
  localparam int ROUNDS  = variant_rounds(VARIANT),
  localparam int RND_W   = $clog2(ROUNDS)
) (
  input  logic [RND_W-1:0] i_idx,
  output logic [W-1:0]     o_k
);

  generate
    if (VARIANT == 512) begin : g_k512
      // 7-bit index reaches past entry 79; those codes never occur but read as zero.
      assign o_k = (i_idx < RND_W'(ROUNDS)) ? K512[i_idx] : '0;
    end else begin : g_k256
      assign o_k = K256[i_idx];
    end
  endgenerate

endmodule

// File: rtl/sha2_k_sequencer.sv
// Streams SHA-2 round constants, LANES per beat, over a valid/ready port.
// Define KSEQ_PREADD_EN to add the w_in input and per-lane K+W output.
module sha2_k_sequencer import sha2_pkg::*; #(
  parameter  int VARIANT = 256,
  parameter  int LANES   = 1,
  localparam int W       = variant_w(VARIANT),
  localparam int ROUNDS  = variant_rounds(VARIANT),
  localparam int BEATS   = ROUNDS / LANES,
  localparam int RND_W   = $clog2(ROUNDS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_flush,
  output logic                 o_busy,
  output logic                 o_k_valid,
  input  logic                 i_k_ready,
  output logic [LANES*W-1:0]   o_k_data,
  output logic [RND_W-1:0]     o_k_round,
  output logic                 o_k_last
`ifdef KSEQ_PREADD_EN
  ,
  input  logic [LANES*W-1:0]   i_w_in,
  output logic [LANES*W-1:0]   o_kw_data
`endif
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'((BEATS - 1) * LANES);

  if (VARIANT != 256 && VARIANT != 512) begin : g_bad_variant
    $error("sha2_k_sequencer: VARIANT must be 256 or 512");
  end
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8) || (ROUNDS % LANES) != 0) begin : g_bad_lanes
    $error("sha2_k_sequencer: LANES must be 1, 2, 4 or 8 and divide ROUNDS");
  end

  kseq_state_e r_state, w_next_state;
  logic [RND_W-1:0]   r_round, w_next_round;
  logic               r_last, w_next_last;
  logic [LANES*W-1:0] r_data;
  logic               w_hs, w_load;
  logic [LANES-1:0][W-1:0]     w_rom;
  logic [LANES-1:0][RND_W-1:0] w_idx;

  always_comb begin
    w_hs         = (r_state == RUN) && i_k_ready;
    w_next_state = r_state;
    w_next_round = r_round;
    w_load       = 1'b0;
    if (i_flush) begin
      w_next_state = IDLE;
      w_next_round = '0;
    end else if (i_start && (r_state == IDLE || (w_hs && r_last))) begin
      // Restart on the last handshake keeps the stream bubble-free.
      w_next_state = RUN;
      w_next_round = '0;
      w_load       = 1'b1;
    end else if (w_hs) begin
      if (r_last) begin
        w_next_state = IDLE;
        w_next_round = '0;
      end else begin
        w_next_round = r_round + RND_W'(LANES);
        w_load       = 1'b1;
      end
    end
    w_next_last = (w_next_state == RUN) && (w_next_round == LAST_RND);
  end

  // ROMs look up the round about to be presented so k_data stays registered.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign w_idx[j] = w_next_round + RND_W'(j);
    sha2_k_rom #(.VARIANT(VARIANT)) u_rom (
      .i_idx (w_idx[j]),
      .o_k   (w_rom[j])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_round <= '0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next_state;
      r_round <= w_next_round;
      r_last  <= w_next_last;
      if (w_load) r_data <= w_rom;
    end
  end

  assign o_busy    = (r_state == RUN);
  assign o_k_valid = (r_state == RUN);
  assign o_k_round = r_round;
  assign o_k_last  = r_last;
  assign o_k_data  = r_data;

`ifdef KSEQ_PREADD_EN
  for (genvar j = 0; j < LANES; j++) begin : g_preadd
    assign o_kw_data[j*W +: W] = r_data[j*W +: W] + i_w_in[j*W +: W];
  end
`endif

endmodule

// File: tb/tb_sha2_k_sequencer.sv
// Directed bench for sha2_k_sequencer: V256/L1, V256/L4 and V512/L1 instances.
module tb_sha2_k_sequencer;

  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // A: 256/L1, B: 256/L4, C: 512/L1
  logic start_a, flush_a, ready_a, busy_a, v_a, last_a;
  logic [31:0] d_a;
  logic [5:0]  r_a;
  logic start_b, flush_b, ready_b, busy_b, v_b, last_b;
  logic [127:0] d_b;
  logic [5:0]   r_b;
  logic start_c, flush_c, ready_c, busy_c, v_c, last_c;
  logic [63:0] d_c;
  logic [6:0]  r_c;
`ifdef KSEQ_PREADD_EN
  logic [31:0]  w_a, kw_a;
  logic [127:0] w_b, kw_b;
  logic [63:0]  w_c, kw_c;
`endif

  sha2_k_sequencer #(.VARIANT(256), .LANES(1)) u_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start_a), .i_flush(flush_a),
    .o_busy(busy_a), .o_k_valid(v_a), .i_k_ready(ready_a), .o_k_data(d_a),
    .o_k_round(r_a), .o_k_last(last_a)
`ifdef KSEQ_PREADD_EN
    , .i_w_in(w_a), .o_kw_data(kw_a)
`endif
  );

  sha2_k_sequencer #(.VARIANT(256), .LANES(4)) u_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start_b), .i_flush(flush_b),
    .o_busy(busy_b), .o_k_valid(v_b), .i_k_ready(ready_b), .o_k_data(d_b),
    .o_k_round(r_b), .o_k_last(last_b)
`ifdef KSEQ_PREADD_EN
    , .i_w_in(w_b), .o_kw_data(kw_b)
`endif
  );

  sha2_k_sequencer #(.VARIANT(512), .LANES(1)) u_c (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start_c), .i_flush(flush_c),
    .o_busy(busy_c), .o_k_valid(v_c), .i_k_ready(ready_c), .o_k_data(d_c),
    .o_k_round(r_c), .o_k_last(last_c)
`ifdef KSEQ_PREADD_EN
    , .i_w_in(w_c), .o_kw_data(kw_c)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    i_rst_n = 1'b0;
    {start_a, flush_a, ready_a} = '0;
    {start_b, flush_b, ready_b} = '0;
    {start_c, flush_c, ready_c} = '0;
`ifdef KSEQ_PREADD_EN
    w_a = '0; w_b = '0; w_c = '0;
`endif
    repeat (2) tick();

    chk("rst_busy_a", busy_a, 0);
    chk("rst_valid_a", v_a, 0);
    chk("rst_last_a", last_a, 0);
    chk("rst_round_a", r_a, 0);
    chk("rst_data_a", d_a, 0);
    chk("rst_data_b", d_b, 0);
    chk("rst_valid_c", v_c, 0);
    chk("rst_data_c", d_c, 0);
    i_rst_n = 1'b1;
    tick();

    // ---- A: full 64-beat run with backpressure at round 5 ----
    ready_a = 1'b1; start_a = 1'b1; tick(); start_a = 1'b0;
    chk("a_b0_valid", v_a, 1);
    chk("a_b0_busy", busy_a, 1);
    chk("a_b0_data", d_a, 32'h428a2f98);
`ifdef KSEQ_PREADD_EN
    w_a = 32'h00000001; #1;
    chk("a_pre_b0", kw_a, 32'h428a2f99);
    w_a = '0;
`endif
    for (int b = 0; b < 64; b++) begin
      chk($sformatf("a_round_%0d", b), r_a, b);
      if (b == 5) begin
        ready_a = 1'b0;
        repeat (3) begin
          tick();
          chk("a_hold_data", d_a, 32'h59f111f1);
          chk("a_hold_round", r_a, 5);
          chk("a_hold_valid", v_a, 1);
        end
        ready_a = 1'b1;
      end
      if (b == 6) chk("a_b6_data", d_a, 32'h923f82a4);
      if (b == 62) chk("a_b62_last", last_a, 0);
      if (b == 63) begin
        chk("a_b63_data", d_a, 32'hc67178f2);
        chk("a_b63_last", last_a, 1);
`ifdef KSEQ_PREADD_EN
        w_a = 32'h40000000; #1;
        chk("a_pre_b63", kw_a, 32'h067178f2);
        w_a = '0;
`endif
      end
      tick();
    end
    chk("a_end_valid", v_a, 0);
    chk("a_end_busy", busy_a, 0);
    chk("a_end_last", last_a, 0);
    chk("a_end_round", r_a, 0);

    // ---- A: control (flush+start, ignored start, zero-bubble restart) ----
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int n = 0; n < 100 && r_a != 6'd10; n++) tick();
    chk("a_reach10", r_a, 10);
    flush_a = 1'b1; start_a = 1'b1; tick(); flush_a = 1'b0; start_a = 1'b0;
    chk("a_flush_valid", v_a, 0);
    chk("a_flush_busy", busy_a, 0);
    chk("a_flush_round", r_a, 0);
    tick();
    chk("a_idle_valid", v_a, 0);
    flush_a = 1'b1; tick(); flush_a = 1'b0;
    chk("a_idleflush_busy", busy_a, 0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("a_restart_valid", v_a, 1);
    chk("a_restart_round", r_a, 0);
    chk("a_restart_data", d_a, 32'h428a2f98);
    for (int n = 0; n < 100 && r_a != 6'd20; n++) tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("a_ignored_start", r_a, 21);
    for (int n = 0; n < 100 && r_a != 6'd63; n++) tick();
    chk("a_pre_last", last_a, 1);
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("a_nobubble_valid", v_a, 1);
    chk("a_nobubble_round", r_a, 0);
    chk("a_nobubble_last", last_a, 0);
    chk("a_nobubble_data", d_a, 32'h428a2f98);
    cnt = 0;
    for (int n = 0; n < 200 && v_a; n++) begin cnt++; tick(); end
    chk("a_nobubble_beats", cnt, 64);

    // ---- B: 256 / LANES=4 ----
    ready_b = 1'b1; start_b = 1'b1; tick(); start_b = 1'b0;
    chk("b_b0_data", d_b, {32'he9b5dba5, 32'hb5c0fbcf, 32'h71374491, 32'h428a2f98});
    cnt = 0;
    for (int n = 0; n < 100 && v_b; n++) begin
      chk($sformatf("b_round_%0d", n), r_b, 4 * n);
      if (last_b) begin
        chk("b_last_round", r_b, 60);
        chk("b_last_data", d_b, {32'hc67178f2, 32'hbef9a3f7, 32'ha4506ceb, 32'h90befffa});
      end
      cnt++;
      tick();
    end
    chk("b_beats", cnt, 16);
    chk("b_end_busy", busy_b, 0);

    // ---- C: 512 / LANES=1 ----
    ready_c = 1'b1; start_c = 1'b1; tick(); start_c = 1'b0;
    chk("c_b0_data", d_c, 64'h428a2f98d728ae22);
    cnt = 0;
    for (int n = 0; n < 200 && v_c; n++) begin
      if (n == 79) begin
        chk("c_b79_round", r_c, 79);
        chk("c_b79_data", d_c, 64'h6c44198c4a475817);
        chk("c_b79_last", last_c, 1);
      end
      cnt++;
      tick();
    end
    chk("c_beats", cnt, 80);
    chk("c_end_busy", busy_c, 0);
    chk("c_end_round", r_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
